button_conditioner: RTL and testbench

//   Front end for the alarm-clock push buttons, sitting between board pins and the system
//   btn_*_export inputs. Per button: synchronise, debounce, one-cycle press/release pulses,

---
 rtl/alarm_btn_pkg.sv | 21 ++
 rtl/btn_channel.sv | 128 ++++++++++++
 rtl/button_conditioner.sv | 40 ++++
 tb/tb_button_conditioner.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alarm_btn_pkg.sv
// Shared constants for the alarm-clock push-button front end.
// Button bit indices, channel FSM encoding and counter sizing helper.
package alarm_btn_pkg;

  localparam int unsigned BTN_UP        = 0;
  localparam int unsigned BTN_DOWN      = 1;
  localparam int unsigned BTN_SET_ALARM = 2;
  localparam int unsigned BTN_SET_CLOCK = 3;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_DELAY  = 2'd1,
    CH_REPEAT = 2'd2
  } ch_state_e;

  // Bits needed to hold 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, press/release
// edge pulses and a hold-to-repeat FSM emitting step pulses.
module btn_channel
  import alarm_btn_pkg::*;
#(
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000,
  parameter bit          REPEAT_EN    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic step_o
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYC);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW = cnt_width(RMAX);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
  localparam logic          RAW_IDLE   = ACTIVE_LOW;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q, deb_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  ch_state_e     state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          step_q, step_d;
  logic          sync_pressed_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= RAW_IDLE;
      sync2_q   <= RAW_IDLE;
      deb_q     <= 1'b0;
      dcnt_q    <= '0;
      state_q   <= CH_IDLE;
      rcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      dcnt_q    <= dcnt_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      step_q    <= step_d;
    end
  end

  always_comb begin
    sync1_d        = raw_i;
    sync2_d        = sync1_q;
    sync_pressed_c = ACTIVE_LOW ? ~sync2_q : sync2_q;
    deb_d          = deb_q;
    dcnt_d         = '0;
    state_d        = state_q;
    rcnt_d         = rcnt_q;
    level_d        = deb_q;
    press_d        = 1'b0;
    release_d      = 1'b0;
    step_d         = 1'b0;

    // Debounce: a new level is accepted only after DEBOUNCE_CYC stable samples.
    if (sync_pressed_c != deb_q) begin
      if (dcnt_q == DB_LAST) begin
        deb_d = sync_pressed_c;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end

    // Edges of the debounced level take priority over repeat timing.
    if (deb_q && !level_q) begin
      press_d = 1'b1;
      step_d  = 1'b1;
      rcnt_d  = '0;
      state_d = REPEAT_EN ? CH_DELAY : CH_IDLE;
    end else if (!deb_q && level_q) begin
      release_d = 1'b1;
      rcnt_d    = '0;
      state_d   = CH_IDLE;
    end else begin
      case (state_q)
        CH_DELAY: begin
          if (rcnt_q == DELAY_LAST) begin
            step_d  = 1'b1;
            rcnt_d  = '0;
            state_d = CH_REPEAT;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
        CH_REPEAT: begin
          if (rcnt_q == RATE_LAST) begin
            step_d = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
        default: rcnt_d = '0;
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign step_o    = step_q;

endmodule

// File: rtl/button_conditioner.sv
// Alarm-clock button front end: one independent conditioning channel per pin.
// Bit map: 0=up, 1=down, 2=set_alarm, 3=set_clock.
module button_conditioner
  import alarm_btn_pkg::*;
#(
  parameter int unsigned N_BTN        = 4,
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK = N_BTN'(4'b0011)
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_step
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .ACTIVE_LOW  (ACTIVE_LOW),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .REPEAT_EN   (REPEAT_MASK[i])
    ) u_ch (
      .clk      (clk_clk),
      .rst      (reset_reset),
      .raw_i    (btn_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .step_o   (btn_step[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing.
module tb_button_conditioner;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic [3:0] btn_raw;
  logic [3:0] btn_level, btn_press, btn_release, btn_step;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] stp;
  } vec_t;

  vec_t vecs[$];

  button_conditioner #(
    .N_BTN       (4),
    .ACTIVE_LOW  (1'b1),
    .DEBOUNCE_CYC(4),
    .REPEAT_DELAY(10),
    .REPEAT_RATE (3),
    .REPEAT_MASK (4'b0011)
  ) dut (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_step   (btn_step)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                           input logic [3:0] rel, input logic [3:0] stp);
    check({tag, " level"},   btn_level,   lvl);
    check({tag, " press"},   btn_press,   prs);
    check({tag, " release"}, btn_release, rel);
    check({tag, " step"},    btn_step,    stp);
  endtask

  task automatic add(input logic [3:0] raw, input logic [3:0] lvl, input logic [3:0] prs,
                     input logic [3:0] rel, input logic [3:0] stp, input int rep);
    vec_t v;
    v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel; v.stp = stp;
    for (int r = 0; r < rep; r++) vecs.push_back(v);
  endtask

  // Press the given bits, hold for 'hold' cycles, release and check every cycle.
  // Press lands 6 edges after the first sampling edge; repeats at +10 then every 3.
  task automatic run_hold(input string tag, input logic [3:0] bits, input int hold,
                          input logic [3:0] rpt);
    int rel_t;
    logic [3:0] lvl, prs, rel, stp;
    rel_t = hold + 7;
    btn_raw = 4'hF & ~bits;
    for (int k = 1; k <= hold + 17; k++) begin
      if (k == hold + 1) btn_raw = 4'hF;
      tick();
      lvl = (k >= 7 && k < rel_t) ? bits : 4'h0;
      prs = (k == 7) ? bits : 4'h0;
      rel = (k == rel_t) ? bits : 4'h0;
      if (k == 7) stp = bits;
      else if (k >= 17 && k < rel_t && ((k - 17) % 3) == 0) stp = bits & rpt;
      else stp = 4'h0;
      check_all($sformatf("%s k=%0d", tag, k), lvl, prs, rel, stp);
    end
  endtask

  initial begin
    reset_reset = 1'b1;
    btn_raw     = 4'hF;
    repeat (3) tick();
    check_all("in_reset", 4'h0, 4'h0, 4'h0, 4'h0);
    reset_reset = 1'b0;
    repeat (3) tick();
    check_all("after_reset", 4'h0, 4'h0, 4'h0, 4'h0);

    // Clean press/release on set_alarm (no repeat), then a 3-cycle glitch on set_clock.
    add(4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 6);
    add(4'hB, 4'h4, 4'h4, 4'h0, 4'h4, 1);
    add(4'hB, 4'h4, 4'h0, 4'h0, 4'h0, 12);
    add(4'hF, 4'h4, 4'h0, 4'h0, 4'h0, 6);
    add(4'hF, 4'h0, 4'h0, 4'h4, 4'h0, 1);
    add(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 3);
    add(4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 3);
    add(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 10);
    foreach (vecs[i]) begin
      btn_raw = vecs[i].raw;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].stp);
    end

    // Bounce on up: 2-cycle toggles never reach the debounce count.
    for (int i = 0; i < 5; i++) begin
      btn_raw = 4'hE;
      repeat (2) begin
        tick();
        check("bounce level", btn_level, 4'h0);
        check("bounce press", btn_press, 4'h0);
      end
      btn_raw = 4'hF;
      repeat (2) begin
        tick();
        check("bounce level", btn_level, 4'h0);
        check("bounce press", btn_press, 4'h0);
      end
    end
    btn_raw = 4'hE;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("settle press k=%0d", k), btn_press, (k == 7) ? 4'h1 : 4'h0);
    end
    btn_raw = 4'hF;
    repeat (15) tick();
    check_all("bounce idle", 4'h0, 4'h0, 4'h0, 4'h0);

    // Auto-repeat on up, then simultaneous down + set_clock (repeat only on down).
    run_hold("repeat", 4'h1, 40, 4'h1);
    run_hold("simul", 4'hA, 30, 4'h2);

    // Reset while up is in the repeat phase, button still held afterwards.
    btn_raw = 4'hE;
    repeat (21) tick();
    check("pre_reset level", btn_level, 4'h1);
    reset_reset = 1'b1;
    tick();
    check_all("reset_mid_repeat", 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    check_all("reset_mid_repeat2", 4'h0, 4'h0, 4'h0, 4'h0);
    reset_reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_all($sformatf("post_reset k=%0d", k), (k >= 7) ? 4'h1 : 4'h0,
                (k == 7) ? 4'h1 : 4'h0, 4'h0, (k == 7) ? 4'h1 : 4'h0);
    end
    btn_raw = 4'hF;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("post_reset release k=%0d", k), btn_release, (k == 7) ? 4'h1 : 4'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
